edge_row_reader: RTL and testbench
==================================

// Module: edge_row_reader
// PURPOSE
//  Read-side client of the edge cache block RAM. On start, sweeps every neighbour of one
//  source node, drives cache addresses {to,from}, absorbs the 1-cycle registered read
//  latency and streams (to_node, weight) beats to the Dijkstra relaxation stage over a
//  valid/ready handshake. This block never drives the cache write port.
// PARAMETERS
//  MAX_NODES    32  nodes per row; sweep covers to = 0..MAX_NODES-1
//  INDEX_WIDTH  5   node index width; cache address = {to[INDEX_WIDTH-1:0], from[INDEX_WIDTH-1:0]}
//  VALUE_WIDTH  32  edge weight width
// PORTS
//  clock           in   1              single clock, rising edge
//  reset_n         in   1              asynchronous, active-low reset
//  start           in   1              1-cycle request; sampled only in IDLE
//  from_node       in   INDEX_WIDTH    source node; latched on accepted start
//  busy            out  1              high from accepted start until done
//  done            out  1              1-cycle pulse: sweep finished, all beats accepted
//  mem_address     out  2*INDEX_WIDTH  cache read address {to,from}
//  mem_edge_value  in   VALUE_WIDTH    cache read data; valid 1 cycle after address is sampled
//  out_valid       out  1              beat available
//  out_ready       in   1              consumer accepts beat when out_valid & out_ready
//  out_to_node     out  INDEX_WIDTH    neighbour index of current beat
//  out_weight      out  VALUE_WIDTH    edge weight of current beat
// BEHAVIOUR
//  - Reset (async, reset_n=0): state IDLE; busy=0, done=0, out_valid=0, mem_address=0,
//    out_to_node=0, out_weight=0, FIFO empty, counters 0. Reset mid-sweep discards in-flight
//    reads and buffered beats; no done pulse.
//  - FSM: IDLE -(start)-> ISSUE -(last address issued)-> DRAIN -(FIFO empty, no read
//    in flight)-> IDLE with done=1 for exactly one cycle. start while busy is ignored.
//  - ISSUE: counter `to` begins at 0; mem_address={to,from_latched}; `to` advances only
//    when the issue condition holds: FIFO occupancy + reads in flight < 2.
//  - Read pipeline: address sampled by the cache at edge E; mem_edge_value captured at E+1
//    together with a registered copy of `to`, and pushed into a 2-entry output FIFO.
//  - Latency: start sampled at edge E0 -> first out_valid high after E2 (out_ready held 1).
//  - Throughput: 1 beat/cycle with out_ready=1; MAX_NODES beats in MAX_NODES+2 cycles
//    from start, done in the cycle after the final handshake.
//  - Backpressure: out_ready=0 holds out_valid, out_to_node, out_weight stable; issuing
//    stalls via the credit rule above, so no beat is ever dropped or duplicated.
//  - Order: beats leave in ascending to_node order.
//  - Wrap: counter width INDEX_WIDTH+1; sweep ends at to==MAX_NODES-1, never wraps to 0.
//  - Weight passes unmodified; no arithmetic on weights in this block.
//  - Simultaneous push and pop on a full FIFO is legal and keeps occupancy at 2.
//  - Outside ISSUE, mem_address holds its last value.
// CONFIGURATION
//  EDGE_READER_SKIP_ABSENT_EN
//   defined:     reads with weight==0 or to==from_latched are not pushed (no beat, no
//                credit consumed after capture); a row with no edges emits zero beats
//                and still pulses done. Sweep timing of mem_address is unchanged.
//   not defined: all MAX_NODES entries emitted, including zero weights and self-loop.
// TESTING
//  1 Reset: assert reset_n=0 mid-sweep at beat 10 -> outputs at reset values same cycle
//    (async); after release, no done, no out_valid until next start.
//  2 Full row, out_ready=1, from=3, cache[{t,3}]=t+100 -> 32 beats to=0..31,
//    weight=100..131, first out_valid 2 edges after start, done 1 cycle after beat 31.
//  3 Backpressure: out_ready toggles 1,0,0,1 repeating -> every beat appears once, in
//    order, data stable while stalled; mem_address never leads the FIFO by >2 entries.
//  4 start re-pulsed while busy with from=7 during from=3 sweep -> ignored; all beats
//    carry from=3 data; next start after done uses from=7.
//  5 EDGE_READER_SKIP_ABSENT_EN defined, from=5, only {2,5}=9 and {5,5}=4 and {30,5}=1
//    non-zero -> exactly 2 beats (2,9),(30,1); self-loop dropped; done pulses once.
//  6 Same define, all-zero row -> zero beats, done pulses after the 32nd read completes.

Source files
------------

// File: rtl/edge_row_reader.sv
// Sweeps one edge-cache row {to,from} for to = 0..MAX_NODES-1 and streams (to, weight) beats.
// Optional build macro EDGE_READER_SKIP_ABSENT_EN drops zero-weight and self-loop reads.
module edge_row_reader #(
  parameter int MAX_NODES   = 32,
  parameter int INDEX_WIDTH = 5,
  parameter int VALUE_WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [INDEX_WIDTH-1:0]     from_node,
  output logic                       busy,
  output logic                       done,
  output logic [2*INDEX_WIDTH-1:0]   mem_address,
  input  logic [VALUE_WIDTH-1:0]     mem_edge_value,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INDEX_WIDTH-1:0]     out_to_node,
  output logic [VALUE_WIDTH-1:0]     out_weight
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam logic [INDEX_WIDTH:0] LAST_TO = (INDEX_WIDTH+1)'(MAX_NODES - 1);

  state_t                   state_q;
  logic [INDEX_WIDTH:0]     to_q;
  logic [INDEX_WIDTH-1:0]   from_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     rd_vld_q;
  logic [INDEX_WIDTH-1:0]   rd_to_q;
  logic [1:0]               cnt_q;
  logic [INDEX_WIDTH-1:0]   slot0_to_q, slot1_to_q;
  logic [VALUE_WIDTH-1:0]   slot0_w_q, slot1_w_q;

  logic       pop;
  logic       push;
  logic [1:0] cnt_after_pop;
  logic [1:0] cnt_d;
  logic       issue;
  logic       drained;

  // Credit counts the FIFO after this cycle's pop plus the read whose data lands next edge,
  // so a full-rate stream keeps issuing while a stalled consumer never overflows the FIFO.
  always_comb begin
    pop           = (cnt_q != 2'd0) && out_ready;
`ifdef EDGE_READER_SKIP_ABSENT_EN
    push          = rd_vld_q && (mem_edge_value != '0) && (rd_to_q != from_q);
`else
    push          = rd_vld_q;
`endif
    cnt_after_pop = cnt_q - {1'b0, pop};
    cnt_d         = cnt_after_pop + {1'b0, push};
    issue         = (state_q == ISSUE) && ((cnt_after_pop + {1'b0, rd_vld_q}) < 2'd2);
    drained       = (state_q == DRAIN) && (cnt_d == 2'd0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      to_q     <= '0;
      from_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_to_q  <= '0;
    end else begin
      done_q   <= 1'b0;
      rd_vld_q <= issue;
      if (issue) rd_to_q <= to_q[INDEX_WIDTH-1:0];
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ISSUE;
            from_q  <= from_node;
            to_q    <= '0;
            busy_q  <= 1'b1;
          end
        end
        ISSUE: begin
          if (issue) begin
            if (to_q == LAST_TO) state_q <= DRAIN;
            else                 to_q    <= to_q + 1'b1;
          end
        end
        DRAIN: begin
          if (drained) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Two-entry FIFO: slot0 is the head driving the outputs; a push lands behind what survives the pop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= 2'd0;
      slot0_to_q <= '0;
      slot1_to_q <= '0;
      slot0_w_q  <= '0;
      slot1_w_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (pop) begin
        slot0_to_q <= slot1_to_q;
        slot0_w_q  <= slot1_w_q;
      end
      if (push) begin
        if (cnt_after_pop == 2'd0) begin
          slot0_to_q <= rd_to_q;
          slot0_w_q  <= mem_edge_value;
        end else begin
          slot1_to_q <= rd_to_q;
          slot1_w_q  <= mem_edge_value;
        end
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_address = {to_q[INDEX_WIDTH-1:0], from_q};
  assign out_valid   = (cnt_q != 2'd0);
  assign out_to_node = slot0_to_q;
  assign out_weight  = slot0_w_q;

endmodule

// File: tb/tb_edge_row_reader.sv
// Scoreboard bench for edge_row_reader: stimulus queues expected beats, a monitor pops and compares.
module tb_edge_row_reader;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [4:0]  from_node;
  logic        busy;
  logic        done;
  logic [9:0]  mem_address;
  logic [31:0] mem_edge_value;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_to_node;
  logic [31:0] out_weight;

  edge_row_reader #(.MAX_NODES(32), .INDEX_WIDTH(5), .VALUE_WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .from_node      (from_node),
    .busy           (busy),
    .done           (done),
    .mem_address    (mem_address),
    .mem_edge_value (mem_edge_value),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_to_node    (out_to_node),
    .out_weight     (out_weight)
  );

  logic [31:0] cache [0:1023];
  logic [36:0] exp_q [$];
  int checks, passes;
  int cyc;
  int beats, done_cnt, done_cyc, last_hs_cyc, start_cyc;
  logic        stall_chk;
  logic [4:0]  held_to;
  logic [31:0] held_w;
  logic        bp_mode;
  int          ph;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Cache model with one-cycle registered read.
  always @(posedge clock) mem_edge_value <= cache[mem_address];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_row(input int f);
    for (int t = 0; t < 32; t++) begin
      logic [31:0] w;
      w = cache[{5'(t), 5'(f)}];
`ifdef EDGE_READER_SKIP_ABSENT_EN
      if (w == 32'd0 || t == f) continue;
`endif
      exp_q.push_back({5'(t), w});
    end
  endtask

  task automatic pulse_start(input logic [4:0] f);
    @(posedge clock); #1;
    start = 1'b1;
    from_node = f;
    @(posedge clock); #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, input string name);
    int k;
    k = 0;
    while (done_cnt == n0 && k < 600) begin
      @(posedge clock);
      k++;
    end
    chk({name, "_done_seen"}, done_cnt, n0 + 1);
    repeat (4) @(posedge clock);
    #1;
    chk({name, "_single_done"}, done_cnt, n0 + 1);
    chk({name, "_busy_low"}, busy, 1'b0);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic wait_beats(input int target);
    int k;
    k = 0;
    while (beats < target && k < 400) begin
      @(posedge clock);
      k++;
    end
    chk("wait_beats_reached", (beats >= target), 1'b1);
  endtask

  initial begin
    int n0, b0;
    reset_n = 1'b0; start = 1'b0; from_node = 5'd0; out_ready = 1'b1;
    bp_mode = 1'b0; ph = 0; stall_chk = 1'b0;
    checks = 0; passes = 0; beats = 0; done_cnt = 0; done_cyc = 0; last_hs_cyc = 0; start_cyc = 0;
    for (int f = 0; f < 32; f++)
      for (int t = 0; t < 32; t++)
        cache[{5'(t), 5'(f)}] = 32'h0001_0000 * f + 32'(t * 7 + 3);
    for (int t = 0; t < 32; t++) begin
      cache[{5'(t), 5'd3}] = 32'(t + 100);
      cache[{5'(t), 5'd7}] = 32'(t + 700);
      cache[{5'(t), 5'd5}] = 32'd0;
      cache[{5'(t), 5'd9}] = 32'd0;
    end
    cache[{5'd2, 5'd5}]  = 32'd9;
    cache[{5'd5, 5'd5}]  = 32'd4;
    cache[{5'd30, 5'd5}] = 32'd1;

    fork
      forever begin
        @(negedge clock);
        if (!reset_n) begin
          stall_chk = 1'b0;
        end else begin
          if (stall_chk) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_to", out_to_node, held_to);
            chk("hold_w", out_weight, held_w);
            stall_chk = 1'b0;
          end
          if (out_valid) begin
            if (out_ready) begin
              if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL extra_beat: got to=%0d w=%0h expected no beat", out_to_node, out_weight);
              end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                chk("beat_to", out_to_node, e[36:32]);
                chk("beat_w", out_weight, e[31:0]);
              end
              beats++;
              last_hs_cyc = cyc;
            end else begin
              stall_chk = 1'b1;
              held_to = out_to_node;
              held_w = out_weight;
            end
          end
          if (done) begin
            done_cnt++;
            done_cyc = cyc;
          end
        end
      end
      forever begin
        logic [3:0] pat;
        pat = 4'b1001;
        @(posedge clock); #1;
        if (bp_mode) begin
          out_ready = pat[ph];
          ph = (ph + 1) % 4;
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_addr", mem_address, 10'd0);
    chk("rst_to", out_to_node, 5'd0);
    chk("rst_w", out_weight, 32'd0);
    reset_n = 1'b1;

    // Full row from=3, consumer always ready
    n0 = done_cnt; b0 = beats;
    for (int t = 0; t < 32; t++) exp_q.push_back({5'(t), 32'(t + 100)});
    pulse_start(5'd3);
    chk("lat_busy", busy, 1'b1);
    chk("lat_addr0", mem_address, {5'd0, 5'd3});
    @(posedge clock); #1;
    chk("lat_e1_valid", out_valid, 1'b0);
    @(posedge clock); #1;
    chk("lat_e2_valid", out_valid, 1'b1);
    wait_done(n0, "row3");
    chk("row3_beats", beats - b0, 32);
    chk("row3_done_cyc", done_cyc - start_cyc, 34);
    chk("row3_done_after_hs", done_cyc - last_hs_cyc, 1);
    chk("row3_addr_hold", mem_address, {5'd31, 5'd3});

    // start re-pulsed with from=7 mid-sweep is ignored
    n0 = done_cnt; b0 = beats;
    for (int t = 0; t < 32; t++) exp_q.push_back({5'(t), 32'(t + 100)});
    pulse_start(5'd3);
    wait_beats(b0 + 5);
    @(posedge clock); #1;
    start = 1'b1; from_node = 5'd7;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(n0, "ignore_start");
    chk("ignore_start_beats", beats - b0, 32);
    n0 = done_cnt; b0 = beats;
    for (int t = 0; t < 32; t++) exp_q.push_back({5'(t), 32'(t + 700)});
    pulse_start(5'd7);
    wait_done(n0, "row7");
    chk("row7_beats", beats - b0, 32);

    // Backpressure 1,0,0,1 on a generic row
    n0 = done_cnt; b0 = beats;
    push_row(11);
    bp_mode = 1'b1;
    pulse_start(5'd11);
    wait_done(n0, "bp");
    bp_mode = 1'b0;
    @(posedge clock); #1;
    out_ready = 1'b1;
    chk("bp_beats", beats - b0, 32);
    chk("bp_done_after_hs", done_cyc - last_hs_cyc, 1);

    // Asynchronous reset mid-sweep
    n0 = done_cnt;
    for (int t = 0; t < 32; t++) exp_q.push_back({5'(t), 32'(t + 100)});
    b0 = beats;
    pulse_start(5'd3);
    wait_beats(b0 + 10);
    @(negedge clock); #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_addr", mem_address, 10'd0);
    chk("mid_rst_to", out_to_node, 5'd0);
    chk("mid_rst_w", out_weight, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    b0 = beats;
    repeat (40) @(posedge clock);
    #1;
    chk("post_rst_no_done", done_cnt, n0);
    chk("post_rst_no_beats", beats, b0);
    chk("post_rst_valid", out_valid, 1'b0);

    // Sparse row from=5 and all-zero row from=9
    n0 = done_cnt; b0 = beats;
`ifdef EDGE_READER_SKIP_ABSENT_EN
    exp_q.push_back({5'd2, 32'd9});
    exp_q.push_back({5'd30, 32'd1});
    pulse_start(5'd5);
    wait_done(n0, "row5");
    chk("row5_beats", beats - b0, 2);
`else
    push_row(5);
    pulse_start(5'd5);
    wait_done(n0, "row5");
    chk("row5_beats", beats - b0, 32);
`endif
    n0 = done_cnt; b0 = beats;
`ifdef EDGE_READER_SKIP_ABSENT_EN
    pulse_start(5'd9);
    wait_done(n0, "row9");
    chk("row9_beats", beats - b0, 0);
    chk("row9_done_cyc", done_cyc - start_cyc, 33);
`else
    push_row(9);
    pulse_start(5'd9);
    wait_done(n0, "row9");
    chk("row9_beats", beats - b0, 32);
    chk("row9_done_cyc", done_cyc - start_cyc, 34);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
